// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential divider.
package div_seq_ctrl_pkg;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/div_seq_ctrl_iter_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract, pick the quotient bit.
// Purely combinational; no backpressure.
module div_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] part_rem,
  input  logic              dvd_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_rem,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // part_rem < divisor always holds, so the extra top bit of trial is a clean borrow flag
  always_comb begin
    shifted  = {part_rem, dvd_msb};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[DATA_W];
    next_rem = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned restoring divider sequencer for the EXE stage (optional DIV_EARLY_OUT_EN).
// Latency: DATA_W+2 cycles from start to res_valid_o; 2 cycles for divide-by-zero or early-out.
// Backpressure: stalls EXE while busy; holds the result in DONE until ack_i; flush_i aborts.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_ITER,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_req_i,
  input  logic              div_signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              flush_i,
  input  logic              ack_i,
  output logic              stall_o,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] quot_o,
  output logic [DATA_W-1:0] rem_o
);

  div_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] part_rem;
  logic [DATA_W-1:0] dvd_sr;
  logic [DATA_W-1:0] dvs_abs;
  logic              q_neg, r_neg;

  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;
  logic              start, div_zero, early;

  div_iter_step #(.DATA_W(DATA_W)) u_step (
    .part_rem (part_rem),
    .dvd_msb  (dvd_sr[DATA_W-1]),
    .divisor  (dvs_abs),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    abs_a    = (div_signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
    abs_b    = (div_signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;
    div_zero = (divisor_i == '0);
`ifdef DIV_EARLY_OUT_EN
    early    = !div_zero && (abs_a < abs_b);
`else
    early    = 1'b0;
`endif
    start    = (state == DIV_IDLE) && div_req_i && !flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = div_req_i && (state != DIV_DONE);
    if (flush_i) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (div_req_i) state_nxt = (div_zero || early) ? DIV_FIX : DIV_RUN;
        DIV_RUN:  if (cnt == CNT_W'(1)) state_nxt = DIV_FIX;
        DIV_FIX:  state_nxt = DIV_DONE;
        DIV_DONE: if (ack_i) state_nxt = DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      part_rem    <= '0;
      dvd_sr      <= '0;
      dvs_abs     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      res_valid_o <= 1'b0;
      quot_o      <= '0;
      rem_o       <= '0;
    end else begin
      res_valid_o <= (state_nxt == DIV_DONE);
      case (state)
        DIV_IDLE: begin
          if (start) begin
            cnt     <= CNT_W'(DATA_W);
            dvs_abs <= abs_b;
            q_neg   <= div_signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
            r_neg   <= div_signed_i & dividend_i[DATA_W-1];
            if (div_zero) begin
              // raw dividend and all-ones quotient, deliberately not sign-fixed
              part_rem <= dividend_i;
              dvd_sr   <= '1;
              q_neg    <= 1'b0;
              r_neg    <= 1'b0;
            end else if (early) begin
              part_rem <= abs_a;
              dvd_sr   <= '0;
            end else begin
              part_rem <= '0;
              dvd_sr   <= abs_a;
            end
          end
        end
        DIV_RUN: begin
          part_rem <= step_rem;
          dvd_sr   <= {dvd_sr[DATA_W-2:0], step_q};
          cnt      <= cnt - CNT_W'(1);
        end
        DIV_FIX: begin
          if (!flush_i) begin
            quot_o <= q_neg ? -dvd_sr   : dvd_sr;
            rem_o  <= r_neg ? -part_rem : part_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed plus randomized bench for div_seq_ctrl against an arithmetic reference model.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i, div_signed_i, flush_i, ack_i;
  logic [31:0] dividend_i, divisor_i;
  logic        stall_o, res_valid_o;
  logic [31:0] quot_o, rem_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_q, last_r;

  div_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .div_signed_i (div_signed_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .flush_i      (flush_i),
    .ack_i        (ack_i),
    .stall_o      (stall_o),
    .res_valid_o  (res_valid_o),
    .quot_o       (quot_o),
    .rem_o        (rem_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Truncating division on magnitudes, then sign rules; latency from the early-exit rules.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    logic [31:0] ua, ub, qa, ra;
    ua = (s && a[31]) ? (32'd0 - a) : a;
    ub = (s && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      lat = 2;
    end else begin
      qa  = ua / ub;
      ra  = ua % ub;
      q   = (s && (a[31] ^ b[31])) ? (32'd0 - qa) : qa;
      r   = (s && a[31]) ? (32'd0 - ra) : ra;
      lat = 34;
`ifdef DIV_EARLY_OUT_EN
      if (ua < ub) lat = 2;
`endif
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int hold);
    logic [31:0] eq, er;
    int lat, cyc, stalls;
    logic got, stable;
    model(a, b, s, eq, er, lat);
    @(negedge clk);
    div_req_i = 1'b1; div_signed_i = s; dividend_i = a; divisor_i = b;
    ack_i = (hold == 0);
    cyc = 0; stalls = 0; got = 1'b0;
    while (!got && cyc < 80) begin
      #1;
      if (stall_o) stalls++;
      if (res_valid_o) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_valid_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_stall_cycles"}, stalls, lat);
    check({tag, "_quot"}, quot_o, eq);
    check({tag, "_rem"}, rem_o, er);
    check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!res_valid_o || quot_o !== eq || rem_o !== er || stall_o) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
    ack_i = 1'b1;
    div_req_i = 1'b0;
    @(negedge clk);
    check({tag, "_idle_after_ack"}, {31'd0, res_valid_o}, 32'd0);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s, seen;
    int          mode;
    rst = 1'b1;
    div_req_i = 1'b0; div_signed_i = 1'b0; flush_i = 1'b0; ack_i = 1'b1;
    dividend_i = '0; divisor_i = '0;
    #12;
    check("rst_valid", {31'd0, res_valid_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_quot", quot_o, 32'd0);
    check("rst_rem", rem_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("u100_7", 32'd100, 32'd7, 1'b0, 0);
    check("u100_7_q_const", last_q, 32'd14);
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    check("s_m7_2_q_const", last_q, 32'hFFFF_FFFD);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    check("s_ovf_q_const", last_q, 32'h8000_0000);
    run_div("dz", 32'h1234, 32'd0, 1'b0, 0);
    run_div("dz_signed", 32'hFFFF_0000, 32'd0, 1'b1, 0);
    run_div("u5_9", 32'd5, 32'd9, 1'b0, 0);
    run_div("s_m5_9", 32'hFFFF_FFFB, 32'd9, 1'b1, 0);
    run_div("hold", 32'd1000, 32'd33, 1'b0, 5);

    // flush in the middle of RUN
    @(negedge clk);
    div_req_i = 1'b1; div_signed_i = 1'b0; dividend_i = 32'd500; divisor_i = 32'd3;
    repeat (10) @(negedge clk);
    check("flush_stall_run", {31'd0, stall_o}, 32'd1);
    flush_i = 1'b1; div_req_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid_o) seen = 1'b1;
    end
    check("flush_no_valid", {31'd0, seen}, 32'd0);
    check("flush_quot_hold", quot_o, last_q);
    check("flush_rem_hold", rem_o, last_r);
    run_div("after_flush_9_3", 32'd9, 32'd3, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case (mode)
        1: b = $urandom_range(1, 255);
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1001, 5000); end
        3: if (i % 3 == 0) b = 32'd0;
        default: ;
      endcase
      run_div("rand", a, b, s, (i % 5 == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for integer division (OP_DIV / OP_DIVU) in the EXE stage.
- Captures operands from the ID/EXE path and runs a radix-2 restoring divide over DATA_W iterations.
- Stalls the pipeline while busy and presents quotient/remainder for the EXE→MEM Lo/Hi path.
- Aborts cleanly on pipeline flush (exception/ERET).

Parameters:
DATA_W, 32, operand/result width
CNT_W, 6, iteration counter width; must be ≥ clog2(DATA_W)+1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
div_req_i  in  1  EXE instruction is OP_DIV/OP_DIVU; held high while EXE is stalled
div_signed_i  in  1  1 = OP_DIV, 0 = OP_DIVU
dividend_i  in  DATA_W  rs value (EXE-forwarded)
divisor_i  in  DATA_W  rt value (EXE-forwarded)
flush_i  in  1  pipeline flush (exception/ERET in WB)
ack_i  in  1  EXE→MEM register advances this cycle
stall_o  out  1  EXE stall request
res_valid_o  out  1  quotient/remainder valid
quot_o  out  DATA_W  quotient → EXE_Lo
rem_o  out  DATA_W  remainder → EXE_Hi

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE, counter=0; quot_o=0, rem_o=0, res_valid_o=0, stall_o=0. Internal partial remainder, quotient and sign flags are cleared.
- States and transitions:
  - IDLE: when div_req_i=1 and flush_i=0, latch |dividend|, |divisor|, quotient sign q_neg = signed & (sign(a) ^ sign(b)), and remainder sign r_neg = signed & sign(a). Load counter=DATA_W and go to RUN.
  - RUN: one restoring step per cycle: shift, trial-subtract, set quotient bit. Decrement counter; at counter==1 go to FIX. This takes exactly DATA_W cycles.
  - FIX: two's-complement quotient if q_neg and remainder if r_neg. Register the results into quot_o/rem_o and go to DONE.
  - DONE: res_valid_o=1. Go to IDLE when ack_i=1; otherwise hold with outputs stable.
- stall_o = div_req_i & (state != DONE). It is combinational and includes the IDLE start cycle.
- Latency: request seen in IDLE at cycle 0 → RUN cycles 1..32 → FIX cycle 33 → DONE cycle 34. stall_o is high for cycles 0..33 (34 cycles).
- Divide by zero (divisor=0): the IDLE start cycle goes directly to FIX. Results: quot=all-ones, rem=dividend (raw, not sign-fixed). res_valid_o rises in cycle 2. No exception is raised (MIPS: result undefined).
- Signed overflow (0x8000_0000 / −1): falls out of the normal path. Results: q=0x8000_0000, r=0. No special case.
- Flush: flush_i in any state forces IDLE on the next edge. res_valid_o drops, and quot_o/rem_o hold their last values. flush_i has priority over ack_i and over a start in IDLE.
- div_req_i deasserting mid-RUN without flush (should not occur) is ignored; the operation completes to DONE and waits for ack_i.
- Back-to-back divides: the DONE→IDLE transition on ack consumes the edge. The next div_req_i in IDLE starts a new operation, so a stale result is never reused.
- res_valid_o is registered. quot_o/rem_o change only on the FIX→DONE edge.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, if |dividend| < |divisor| (unsigned compare of absolute values) and divisor≠0, skip RUN and go to FIX with quotient=0 and remainder=|dividend|, then sign-fix as normal. res_valid_o rises in cycle 2.
- Undefined: every non-zero-divisor divide takes the full 34-cycle path. Results are identical either way.

Decomposition:
- CPU_Defines.svh: typedef enum logic [1:0] DivStateType {DIV_IDLE, DIV_RUN, DIV_FIX, DIV_DONE}; constant DIV_ITER = 32.
- One sub-module, div_iter_step (combinational, one restoring step):
  - Inputs: partial remainder, dividend shift register, divisor.
  - Outputs: next partial remainder, next quotient bit.
  - div_seq_ctrl owns the FSM, counter, sign handling and output registers.

Test Plan:
- Unsigned 100/7, ack_i tied 1 → stall_o high 34 cycles; res_valid_o in cycle 34; quot=14, rem=2; IDLE in cycle 35.
- Signed −7/2 (0xFFFF_FFF9 / 2) → quot=0xFFFF_FFFD, rem=0xFFFF_FFFF. Signed 0x8000_0000 / 0xFFFF_FFFF → quot=0x8000_0000, rem=0.
- Divisor 0, dividend 0x1234 → res_valid_o in cycle 2; quot=0xFFFF_FFFF, rem=0x1234.
- flush_i at RUN cycle 10 → IDLE next edge, res_valid_o never rises; a new unsigned 9/3 issued after completes with quot=3, rem=0.
- ack_i held 0 for 5 cycles in DONE → res_valid_o, quot_o, rem_o stable; stall_o=0; IDLE one cycle after ack_i=1.
- DIV_EARLY_OUT_EN defined, unsigned 5/9 → res_valid_o in cycle 2, quot=0, rem=5. Undefined → same values in cycle 34.
